// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit: multi-cycle load-use stall detector with in-flight load age tracker.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module load_use_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             freeze,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             bubble,
  output logic             load_pending,
  output logic [CNT_W-1:0] stall_count
);
  // With LOAD_LAT=1 a single always-invalid entry stands in for the empty tracker.
  localparam int N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  logic             cap_v;
  logic [N-1:0]     trk_v;
  logic [REG_W-1:0] trk_d [N];
  logic [N:0]       m;
  logic             hazard;
  function automatic logic src_match(input logic v, input logic [REG_W-1:0] d,
                                     input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                     input logic urs, input logic urt);
    return v & ((urs & (rs == d) & (rs != '0)) | (urt & (rt == d) & (rt != '0)));
  endfunction
  assign cap_v = ex_valid & ex_memread & (ex_rt != '0);
  assign m[0]  = src_match(cap_v, ex_rt, id_rs, id_rt, id_use_rs, id_use_rt);
  for (genvar g = 0; g < N; g++) begin : g_match
    assign m[g+1] = src_match(trk_v[g], trk_d[g], id_rs, id_rt, id_use_rs, id_use_rt);
  end
  if (LOAD_LAT > 1) begin : g_trk
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        trk_v <= '0;
        for (int i = 0; i < N; i++) trk_d[i] <= '0;
      end else if (!freeze) begin
        for (int i = N - 1; i > 0; i--) begin
          trk_v[i] <= trk_v[i-1];
          trk_d[i] <= trk_d[i-1];
        end
        trk_v[0] <= cap_v;
        trk_d[0] <= ex_rt;
      end
    end
  end else begin : g_no_trk
    assign trk_v    = '0;
    assign trk_d[0] = '0;
  end
  assign hazard       = id_valid & (|m);
  assign stall        = hazard & ~flush;
  assign bubble       = stall & ~freeze;
  assign load_pending = |trk_v;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (bubble && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
  assign stall_count = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_count    = '0;
`endif
endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb_load_use_hazard_unit: vector table, directed corner sequences and randomized model check.
module tb_load_use_hazard_unit;
  localparam int REG_W = 5, LAT = 2, CNT_W = 32;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, id_use_rs = 0, id_use_rt = 0, ex_valid = 0, ex_memread = 0;
  logic freeze = 0, flush = 0, cnt_clr = 0;
  logic [REG_W-1:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic stall, bubble, load_pending;
  logic [CNT_W-1:0] stall_count;
  int checks = 0, failures = 0;
  int q[$];
  longint mcnt;
  load_use_hazard_unit #(.REG_W(REG_W), .LOAD_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr), .stall(stall),
    .bubble(bubble), .load_pending(load_pending), .stall_count(stall_count));
  always #5 clk = ~clk;
  typedef struct {
    logic iv; int rs; int rt; logic urs; logic urt;
    logic ev; logic em; int ert; logic frz; logic fl;
    logic e_stall; logic e_bubble;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask
  task automatic drive(input logic iv, input int rs, input int rt, input logic urs, input logic urt,
                       input logic ev, input logic em, input int ert, input logic frz, input logic fl);
    id_valid = iv; id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_use_rs = urs; id_use_rt = urt;
    ex_valid = ev; ex_memread = em; ex_rt = REG_W'(ert); freeze = frz; flush = fl; cnt_clr = 0;
  endtask
  task automatic step(input logic iv, input int rs, input int rt, input logic urs, input logic urt,
                      input logic ev, input logic em, input int ert, input logic frz, input logic fl);
    @(negedge clk);
    drive(iv, rs, rt, urs, urt, ev, em, ert, frz, fl);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    #2 rst_n = 1;
    q.delete();
    mcnt = 0;
  endtask
  function automatic bit uses(int d);
    return d != 0 && ((id_use_rs && int'(id_rs) == d) || (id_use_rt && int'(id_rt) == d));
  endfunction
  function automatic int cap();
    return (ex_valid && ex_memread && ex_rt != 0) ? int'(ex_rt) : 0;
  endfunction
  function automatic bit m_stall();
    bit h = uses(cap());
    foreach (q[i]) h |= uses(q[i]);
    return id_valid && h && !flush;
  endfunction
  function automatic bit m_pending();
    bit p = 0;
    foreach (q[i]) p |= (q[i] != 0);
    return p;
  endfunction
  function automatic longint exp_cnt(longint c);
`ifdef HAZARD_STALL_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction
  initial begin
    // iv rs rt urs urt ev em ert frz fl -> stall bubble (fresh tracker each row)
    tbl[0]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 5, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    tbl[4]  = '{1, 2, 9, 1, 1, 1, 1, 2, 0, 0, 1, 1};
    tbl[5]  = '{1, 9, 3, 1, 1, 1, 1, 3, 0, 0, 1, 1};
    tbl[6]  = '{1, 3, 9, 0, 1, 1, 1, 3, 0, 0, 0, 0};
    tbl[7]  = '{1, 4, 4, 1, 1, 1, 1, 4, 0, 1, 0, 0};
    tbl[8]  = '{1, 4, 4, 1, 1, 1, 1, 4, 1, 0, 1, 0};
    tbl[9]  = '{1, 6, 6, 1, 1, 0, 1, 6, 0, 0, 0, 0};
    tbl[10] = '{1, 6, 6, 1, 1, 1, 0, 6, 0, 0, 0, 0};
    do_reset();
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_bubble", bubble, 0);
    chk("reset_pending", load_pending, 0);
    chk("reset_count", stall_count, 0);
    for (int i = 0; i < 11; i++) begin
      do_reset();
      step(tbl[i].iv, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
           tbl[i].ev, tbl[i].em, tbl[i].ert, tbl[i].frz, tbl[i].fl);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_bubble", i), bubble, tbl[i].e_bubble);
    end
    // Dependent add behind load $1: two stall cycles then release.
    do_reset();
    step(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
    chk("dep_c0_stall", stall, 1); chk("dep_c0_bubble", bubble, 1);
    step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("dep_c1_stall", stall, 1); chk("dep_c1_bubble", bubble, 1);
    chk("dep_c1_pending", load_pending, 1);
    step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("dep_c2_stall", stall, 0); chk("dep_c2_pending", load_pending, 0);
    chk("dep_count", stall_count, exp_cnt(2));
    @(negedge clk); cnt_clr = 1; @(negedge clk); cnt_clr = 0; #1;
    chk("cnt_clr", stall_count, 0);
    // Load $0 never tracked.
    do_reset();
    step(1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    chk("zero_stall", stall, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_pending", load_pending, 0);
    // Freeze for 3 cycles from the load's EX cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 3, 1, 1, 1, 1, 3, 1, 0);
      chk($sformatf("frz%0d_stall", i), stall, 1);
      chk($sformatf("frz%0d_bubble", i), bubble, 0);
      chk($sformatf("frz%0d_pending", i), load_pending, 0);
    end
    step(1, 3, 3, 1, 1, 1, 1, 3, 0, 0);
    chk("frz3_stall", stall, 1); chk("frz3_bubble", bubble, 1);
    step(1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    chk("frz4_stall", stall, 1); chk("frz4_bubble", bubble, 1);
    step(1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    chk("frz5_stall", stall, 0);
    chk("frz_count", stall_count, exp_cnt(2));
    // Flush suppresses the stall, tracker still captures.
    do_reset();
    step(1, 4, 4, 1, 1, 1, 1, 4, 0, 1);
    chk("flush_stall", stall, 0); chk("flush_bubble", bubble, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_pending", load_pending, 1);
    // Async reset mid-stall.
    do_reset();
    step(1, 7, 7, 1, 1, 1, 1, 7, 0, 0);
    chk("rst_c0_stall", stall, 1);
    step(1, 7, 7, 1, 1, 0, 0, 0, 0, 0);
    chk("rst_c1_stall", stall, 1);
    chk("rst_c1_count", stall_count, exp_cnt(1));
    rst_n = 0;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_pending", load_pending, 0);
    chk("rst_mid_count", stall_count, 0);
    #1 rst_n = 1;
    // Randomized against queue-of-load-ages model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit es, eb;
      @(negedge clk);
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
            $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0));
      cnt_clr = 1'($urandom_range(0, 15) == 0);
      #1;
      es = m_stall();
      eb = es && !freeze;
      chk("rnd_stall", stall, es);
      chk("rnd_bubble", bubble, eb);
      chk("rnd_pending", load_pending, m_pending());
      chk("rnd_count", stall_count, exp_cnt(mcnt));
      @(posedge clk);
      if (!freeze) begin
        q.push_front(cap());
        while (q.size() > LAT - 1) void'(q.pop_back());
      end
      if (cnt_clr) mcnt = 0;
      else if (eb && mcnt < 64'hFFFF_FFFF) mcnt++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_use_hazard_unit.md
# load_use_hazard_unit

Parametrised load-use hazard detector for the MIPS pipeline, sitting beside the ID stage and watching EX plus a short history of recently issued loads. It supports data memories with multi-cycle load latency by tracking in-flight load destinations in an age shift register. It stalls the consumer in ID for exactly as many cycles as needed. Compared with the single-cycle detector, it adds per-operand use qualifiers, exclusion of register `$0`, flush suppression, pipeline-freeze awareness and an optional stall counter.

## Interface
- `REG_W`, default 5: register address width.
- `LOAD_LAT`, default 2: number of bubbles required between a load in EX and a dependent instruction reaching EX; legal range 1..4.
- `CNT_W`, default 32: stall counter width.

- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W  ID source register fields.
- `id_use_rs`, `id_use_rt`  in  1  ID instruction actually reads rs / rt.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_memread`  in  1  EX instruction is a load.
- `ex_rt`  in  REG_W  load destination in EX.
- `freeze`  in  1  whole pipeline held, for example during a data-memory wait.
- `flush`  in  1  ID/IF are being squashed this cycle.
- `cnt_clr`  in  1  synchronous clear of `stall_count`.
- `stall`  out  1  hold PC and IF/ID.
- `bubble`  out  1  insert NOP into ID/EX.
- `load_pending`  out  1  any valid tracker entry.
- `stall_count`  out  CNT_W  stalled-cycle count.

## Operation
- The age tracker has `LOAD_LAT-1` entries. Each entry holds {valid, dst}; entry i holds the load that was in EX i cycles ago. The EX inputs form age 0 combinationally.
- Tracker capture value: valid = `ex_valid & ex_memread & (ex_rt != 0)`, dst = `ex_rt`.
- Source match against entry e: `e.valid & ((id_use_rs & id_rs==e.dst & id_rs!=0) | (id_use_rt & id_rt==e.dst & id_rt!=0))`.
- `hazard` = `id_valid` AND a match against age 0 or any tracker entry.
- `stall` = `hazard & ~flush`.
- `bubble` = `stall & ~freeze`.
- `load_pending` = OR of tracker valid bits. It is constant 0 when `LOAD_LAT`=1 (no tracker).
- A bubble enters EX as invalid, so the tracker fills with invalid entries behind the load. This makes the stall self-terminating.
- Multiple matching loads: the stall persists until the youngest match ages out. No extra state is needed.

## Timing
- Reset: all tracker entries invalid; `stall_count`=0. With `id_valid`=0, `stall`=`bubble`=`load_pending`=0.
- Reset asserted mid-stall clears the tracker immediately. `stall` drops in the same cycle, because it is combinational on cleared state.
- Tracker update at each `clk` rising edge when `freeze`=0: entry1 ← capture value, entry i+1 ← entry i. When `freeze`=1, all entries hold.
- A dependent instruction entering ID while the load is in EX sees exactly `LOAD_LAT` cycles of `stall`=1, assuming no freeze.
- Freeze cycles extend the stall one-for-one; `bubble` stays 0 during freeze.
- `flush` overrides the hazard in the same cycle. The tracker still shifts normally, because older loads remain live.
- `stall`, `bubble` and `load_pending` are combinational outputs. `stall_count` is registered.

## Configuration
- Macro `HAZARD_STALL_CNT_EN`.
- Defined: `stall_count` increments by 1 on each edge where `bubble`=1 and saturates at all-ones. `cnt_clr` takes priority over increment.
- Undefined: no counter flops; `stall_count` is tied to 0 and `cnt_clr` is ignored.

## Test plan
- `LOAD_LAT`=2. Load `$1` in EX, ID `add $2,$1,$1` (both uses) -> `stall`=`bubble`=1 for exactly 2 cycles, then 0; with the macro defined, `stall_count`=2.
- Load `$0` in EX, ID reads `$0` -> `stall`=0; `load_pending`=0 the next cycle.
- Load `$1` in EX, ID `addi $1,$5,4` (`id_use_rt`=0, `id_rt`=1, `id_rs`=5) -> `stall`=0.
- Load `$3`, dependent in ID, `freeze`=1 for 3 cycles starting at the load's EX cycle -> `stall`=1 for 5 cycles total, `bubble`=1 only on the 2 non-frozen cycles, tracker holds during freeze.
- Load `$4`, dependent in ID, `flush`=1 on the first cycle -> `stall`=0 that cycle; `load_pending`=1 the next cycle.
- Load `$7`, `stall` active, `rst_n` pulsed low on the second stall cycle -> `stall`=0 and `load_pending`=0 immediately; `stall_count` cleared to 0.
